// File: rtl/rtx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtx_pkg
// Description : Shared ray-tracer types and constants: RGB color, pixel
//               coordinate, scheduler state encoding and frame defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package rtx_pkg;

    // Default frame geometry
    localparam int SIZE_H_DEFAULT = 320;
    localparam int SIZE_V_DEFAULT = 180;

    // Coordinate bus widths (2048 columns x 1024 rows max)
    localparam int COORD_H_W = 11;
    localparam int COORD_V_W = 10;

    // RGB color, one byte per channel
    typedef logic [2:0][7:0] color_t;

    // Pixel coordinate as carried through the in-flight FIFO
    typedef struct packed {
        logic [COORD_V_W-1:0] v;
        logic [COORD_H_W-1:0] h;
    } coord_t;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // True when value is a positive power of two
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage : rtx_pkg
`default_nettype wire

// File: rtl/coord_fifo.sv
`default_nettype none
// ============================================================================
// Module      : coord_fifo
// Description : Synchronous show-ahead FIFO. The head entry is always visible
//               on pop_data. A pop on a full FIFO frees its slot in the same
//               cycle, so a simultaneous push is accepted. Pops on an empty
//               FIFO and pushes on a full FIFO without a pop are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module coord_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 21
) (
    input  logic                       clk_rtx,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == C_DEPTH);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clk_rtx) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely
    always_ff @(posedge clk_rtx) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : coord_fifo
`default_nettype wire

// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scheduler
// Description : Walks the frame in raster order issuing ray requests to the
//               tracer, keeps the issued coordinates in an in-order FIFO, and
//               pairs each returning color with its coordinate to produce a
//               registered frame-buffer write.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scheduler
    import rtx_pkg::*;
#(
    parameter int SIZE_H       = rtx_pkg::SIZE_H_DEFAULT,
    parameter int SIZE_V       = rtx_pkg::SIZE_V_DEFAULT,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                  clk_rtx,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  ray_req_valid,
    input  logic                  ray_req_ready,
    output logic [COORD_H_W-1:0]  ray_req_h,
    output logic [COORD_V_W-1:0]  ray_req_v,
    input  logic                  ray_resp_valid,
    input  color_t                ray_resp_color,
    output logic [COORD_H_W-1:0]  pixel_h,
    output logic [COORD_V_W-1:0]  pixel_v,
    output color_t                new_color,
    output logic                  new_color_valid,
    output logic [15:0]           frame_count,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  resp_err
);

    // Elaboration-time parameter checks
    generate
        if (SIZE_H * SIZE_V < 4) begin : g_bad_frame_size
            $error("pixel_scheduler: SIZE_H*SIZE_V must be at least 4");
        end
        if (SIZE_H < 1 || SIZE_H > 2048 || SIZE_V < 1 || SIZE_V > 1024) begin : g_bad_geometry
            $error("pixel_scheduler: frame does not fit the coordinate buses");
        end
        if (!is_pow2(MAX_INFLIGHT) || MAX_INFLIGHT < 2 || MAX_INFLIGHT > 64) begin : g_bad_inflight
            $error("pixel_scheduler: MAX_INFLIGHT must be a power of two in 2..64");
        end
    endgenerate

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [COORD_H_W-1:0] H_LAST   = COORD_H_W'(SIZE_H - 1);
    localparam logic [COORD_V_W-1:0] V_LAST   = COORD_V_W'(SIZE_V - 1);
    localparam logic [CW-1:0]        ONE_LEFT = CW'(1);

    sched_state_t     state;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [$bits(coord_t)-1:0] head_bits;
    coord_t           head;
    coord_t           cursor;
    logic             req_fire;
    logic             resp_pop;
    logic             last_issue;
    logic             last_write;

    // Requests only while issuing and a FIFO slot is free; both terms are
    // flops, so valid cannot drop during a stall (occupancy only falls then)
    assign ray_req_valid = (state == ST_ISSUE) && !fifo_full;
    assign req_fire      = ray_req_valid && ray_req_ready;

    // A response with nothing outstanding is an error and never pops
    assign resp_pop      = ray_resp_valid && !fifo_empty;

    assign last_issue    = req_fire && (ray_req_h == H_LAST) && (ray_req_v == V_LAST);

    // No pushes happen in DRAIN, so the last outstanding entry is the final pixel
    assign last_write    = (state == ST_DRAIN) && resp_pop && (fifo_count == ONE_LEFT);

    assign cursor        = '{v: ray_req_v, h: ray_req_h};
    assign head          = coord_t'(head_bits);

    coord_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH ($bits(coord_t))
    ) u_coord_fifo (
        .clk_rtx   (clk_rtx),
        .rst       (rst),
        .push      (req_fire),
        .push_data (cursor),
        .pop       (resp_pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame sequencing: state, raster cursor, busy and frame bookkeeping
    always_ff @(posedge clk_rtx) begin
        if (rst) begin
            state       <= ST_IDLE;
            ray_req_h   <= '0;
            ray_req_v   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_ISSUE;
                        busy      <= 1'b1;
                        ray_req_h <= '0;
                        ray_req_v <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (req_fire) begin
                        if (last_issue) begin
                            // Cursor parks at the origin ready for the next frame
                            state     <= ST_DRAIN;
                            ray_req_h <= '0;
                            ray_req_v <= '0;
                        end else if (ray_req_h == H_LAST) begin
                            ray_req_h <= '0;
                            ray_req_v <= ray_req_v + COORD_V_W'(1);
                        end else begin
                            ray_req_h <= ray_req_h + COORD_H_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_write) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        if (enable) begin
                            state <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write path: pair each response with the FIFO head one cycle later
    always_ff @(posedge clk_rtx) begin
        if (rst) begin
            new_color_valid <= 1'b0;
            pixel_h         <= '0;
            pixel_v         <= '0;
            new_color       <= '0;
            resp_err        <= 1'b0;
        end else begin
            new_color_valid <= resp_pop;
            if (resp_pop) begin
                pixel_h   <= head.h;
                pixel_v   <= head.v;
                new_color <= ray_resp_color;
            end
            if (ray_resp_valid && fifo_empty) begin
                resp_err <= 1'b1;
            end
        end
    end

endmodule : pixel_scheduler
`default_nettype wire

// File: tb/tb_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_scheduler
// Description : Self-checking bench for pixel_scheduler on a 4x2 frame with
//               four outstanding requests. A pixel-index model predicts every
//               output each cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_scheduler;
    import rtx_pkg::*;

    localparam int SH = 4;
    localparam int SV = 2;
    localparam int MI = 4;
    localparam int NPIX = SH * SV;

    logic         clk_rtx;
    logic         rst;
    logic         enable;
    logic         ray_req_valid;
    logic         ray_req_ready;
    logic [10:0]  ray_req_h;
    logic [9:0]   ray_req_v;
    logic         ray_resp_valid;
    color_t       ray_resp_color;
    logic [10:0]  pixel_h;
    logic [9:0]   pixel_v;
    color_t       new_color;
    logic         new_color_valid;
    logic [15:0]  frame_count;
    logic         frame_done;
    logic         busy;
    logic         resp_err;

    pixel_scheduler #(
        .SIZE_H       (SH),
        .SIZE_V       (SV),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk_rtx         (clk_rtx),
        .rst             (rst),
        .enable          (enable),
        .ray_req_valid   (ray_req_valid),
        .ray_req_ready   (ray_req_ready),
        .ray_req_h       (ray_req_h),
        .ray_req_v       (ray_req_v),
        .ray_resp_valid  (ray_resp_valid),
        .ray_resp_color  (ray_resp_color),
        .pixel_h         (pixel_h),
        .pixel_v         (pixel_v),
        .new_color       (new_color),
        .new_color_valid (new_color_valid),
        .frame_count     (frame_count),
        .frame_done      (frame_done),
        .busy            (busy),
        .resp_err        (resp_err)
    );

    initial clk_rtx = 1'b0;
    always #5 clk_rtx = ~clk_rtx;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- cycle counter and tracer ----------------
    int  cyc = 0;
    int  auto_lag = 0;
    bit  inject_resp = 0;
    int  col_n = 1;
    int  due[$];
    int  hs_count = 0;
    int  wr_log[$];

    always @(posedge clk_rtx) cyc <= cyc + 1;

    // Tracer: responds in order a fixed lag after each handshake, or once on demand
    always begin
        @(posedge clk_rtx);
        #2;
        ray_resp_valid = 1'b0;
        if (rst) due.delete();
        if (inject_resp || (auto_lag > 0 && due.size() > 0 && due[0] <= cyc)) begin
            if (!inject_resp) void'(due.pop_front());
            inject_resp    = 1'b0;
            ray_resp_valid = 1'b1;
            ray_resp_color = {8'(col_n * 3), 8'(col_n + 8'h40), 8'(~col_n)};
            col_n++;
        end
    end

    // ---------------- behavioural model ----------------
    bit          m_active = 0;
    int          m_issued = 0;
    int          m_written = 0;
    int          m_q[$];
    int          m_frames = 0;
    bit          m_err = 0;
    bit          m_wv = 0;
    bit          m_done = 0;
    int          m_ph = 0;
    int          m_pv = 0;
    logic [23:0] m_col = '0;

    function automatic bit model_req_valid();
        return m_active && (m_issued < NPIX) && (m_q.size() < MI);
    endfunction

    // Compare DUT with model, then advance the model with the inputs now applied
    always @(negedge clk_rtx) begin
        bit ev;
        bit was_active;
        ev = model_req_valid();
        chk("req_valid", 32'(ray_req_valid), 32'(ev));
        if (ev) begin
            chk("req_h", 32'(ray_req_h), 32'(m_issued % SH));
            chk("req_v", 32'(ray_req_v), 32'(m_issued / SH));
        end
        chk("wr_valid", 32'(new_color_valid), 32'(m_wv));
        chk("pixel_h", 32'(pixel_h), 32'(m_ph));
        chk("pixel_v", 32'(pixel_v), 32'(m_pv));
        chk("color", 32'(new_color), 32'(m_col));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_count", 32'(frame_count), 32'(m_frames[15:0]));
        chk("busy", 32'(busy), 32'(m_active));
        chk("resp_err", 32'(resp_err), 32'(m_err));

        // Logs of observed traffic for directed checks and tracer timing
        if (new_color_valid) wr_log.push_back(int'(pixel_v) * 100 + int'(pixel_h));
        if (!rst && ray_req_valid && ray_req_ready) begin
            hs_count++;
            if (auto_lag > 0) due.push_back(cyc + auto_lag);
        end

        if (rst) begin
            m_active = 0; m_issued = 0; m_written = 0; m_q.delete();
            m_frames = 0; m_err = 0; m_wv = 0; m_done = 0;
            m_ph = 0; m_pv = 0; m_col = '0;
        end else begin
            was_active = m_active;
            m_wv = 0;
            m_done = 0;
            if (ray_resp_valid) begin
                if (m_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    int idx;
                    idx = m_q.pop_front();
                    m_wv = 1;
                    m_ph = idx % SH;
                    m_pv = idx / SH;
                    m_col = ray_resp_color;
                    m_written++;
                    if (m_written == NPIX) begin
                        m_done = 1;
                        m_frames++;
                        m_written = 0;
                        m_issued = 0;
                        m_active = enable;
                    end
                end
            end
            if (ev && ray_req_ready) begin
                m_q.push_back(m_issued);
                m_issued++;
            end else if (!was_active && enable) begin
                m_active = 1;
                m_issued = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_rtx);
            #1;
        end
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycles(1);
            seen = frame_done;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic check_frame_log(input int base, input string nm);
        chk({nm, "_count"}, 32'(wr_log.size() - base), 32'(NPIX));
        for (int i = 0; i < NPIX && base + i < wr_log.size(); i++) begin
            chk(nm, 32'(wr_log[base + i]), 32'((i / SH) * 100 + (i % SH)));
        end
    endtask

    initial begin
        int wr_base;
        int hs_base;
        bit seen;
        rst = 1'b1;
        enable = 1'b0;
        ray_req_ready = 1'b0;
        ray_resp_valid = 1'b0;
        ray_resp_color = '0;
        cycles(3);
        chk("rst_req_valid", 32'(ray_req_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        cycles(1);

        // Full frame, ready=1, 2-cycle response lag, enable dropped mid-frame
        wr_base = wr_log.size();
        ray_req_ready = 1'b1;
        auto_lag = 2;
        enable = 1'b1;
        cycles(2);
        enable = 1'b0;
        wait_done(100, "t1_done");
        cycles(2);
        check_frame_log(wr_base, "t1_raster");
        chk("t1_frame_count", 32'(frame_count), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Restart from (0,0) with ready toggling every cycle
        wr_base = wr_log.size();
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycles(1);
            seen = ray_req_valid;
        end
        chk("t2_restart_valid", 32'(seen), 32'd1);
        chk("t2_restart_h", 32'(ray_req_h), 32'd0);
        chk("t2_restart_v", 32'(ray_req_v), 32'd0);
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            ray_req_ready = ~ray_req_ready;
            cycles(1);
            seen = frame_done;
        end
        chk("t2_done", 32'(seen), 32'd1);
        ray_req_ready = 1'b1;
        cycles(2);
        check_frame_log(wr_base, "t2_raster");
        chk("t2_frame_count", 32'(frame_count), 32'd2);

        // No responses: exactly MI handshakes, then one response frees one slot
        auto_lag = 0;
        hs_base = hs_count;
        enable = 1'b1;
        cycles(1);
        enable = 1'b0;
        cycles(10);
        chk("t3_hs_limit", 32'(hs_count - hs_base), 32'd4);
        chk("t3_valid_full", 32'(ray_req_valid), 32'd0);
        inject_resp = 1'b1;
        cycles(4);
        chk("t3_hs_after_resp", 32'(hs_count - hs_base), 32'd5);
        chk("t3_valid_refull", 32'(ray_req_valid), 32'd0);
        ray_req_ready = 1'b0;
        inject_resp = 1'b1;
        cycles(3);
        chk("t3_valid_three", 32'(ray_req_valid), 32'd1);

        // Reset mid-frame with three outstanding
        rst = 1'b1;
        cycles(1);
        chk("t4_req_valid", 32'(ray_req_valid), 32'd0);
        chk("t4_wr_valid", 32'(new_color_valid), 32'd0);
        chk("t4_frame_done", 32'(frame_done), 32'd0);
        chk("t4_frame_count", 32'(frame_count), 32'd0);
        chk("t4_resp_err", 32'(resp_err), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_pixel", {11'd0, pixel_v, pixel_h}, 32'd0);
        chk("t4_color", 32'(new_color), 32'd0);
        rst = 1'b0;

        // Late response after reset finds the FIFO empty
        inject_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            chk("t5_no_write", 32'(new_color_valid), 32'd0);
        end
        chk("t5_resp_err", 32'(resp_err), 32'd1);

        // Back-to-back frames with enable held across the boundary
        ray_req_ready = 1'b1;
        auto_lag = 1;
        enable = 1'b1;
        wait_done(100, "t6_done1");
        enable = 1'b0;
        wait_done(100, "t6_done2");
        cycles(2);
        chk("t6_frame_count", 32'(frame_count), 32'd2);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err_sticky", 32'(resp_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_pixel_scheduler
`default_nettype wire
